// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Types and constants shared by the seven-segment encoder and the scan
//   decoder: the segment-vector type, the 16 hex segment patterns
//   (active-low, index 0 = segment a ... index 6 = segment g), the decoder
//   FSM state enum, and the stability-counter width.
//   No ports (package).
package seg7_pkg;

  typedef logic [0:6] seg_vec_t;

  localparam seg_vec_t SEG_HEX_0 = 7'b0000001;
  localparam seg_vec_t SEG_HEX_1 = 7'b1001111;
  localparam seg_vec_t SEG_HEX_2 = 7'b0010010;
  localparam seg_vec_t SEG_HEX_3 = 7'b0000110;
  localparam seg_vec_t SEG_HEX_4 = 7'b1001100;
  localparam seg_vec_t SEG_HEX_5 = 7'b0100100;
  localparam seg_vec_t SEG_HEX_6 = 7'b0100000;
  localparam seg_vec_t SEG_HEX_7 = 7'b0001111;
  localparam seg_vec_t SEG_HEX_8 = 7'b0000000;
  localparam seg_vec_t SEG_HEX_9 = 7'b0000100;
  localparam seg_vec_t SEG_HEX_A = 7'b0001000;
  localparam seg_vec_t SEG_HEX_B = 7'b1100000;
  localparam seg_vec_t SEG_HEX_C = 7'b0110001;
  localparam seg_vec_t SEG_HEX_D = 7'b1000010;
  localparam seg_vec_t SEG_HEX_E = 7'b0110000;
  localparam seg_vec_t SEG_HEX_F = 7'b0111000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } scan_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational lookup of an active-low seven-segment pattern into its
//   hex nibble.
//   Ports:
//     pattern [0:6]  segment pattern, bit 0 = a ... bit 6 = g (active-low)
//     nibble  [3:0]  decoded hex value (0 when the pattern is not legal)
//     legal          1 when the pattern is one of the 16 hex glyphs
module seg7_pattern_decode (
  input  logic [0:6] pattern,
  output logic [3:0] nibble,
  output logic       legal
);
  import seg7_pkg::*;

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (pattern)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Snoops a multiplexed seven-segment display bus and recovers the hex word
//   being shown. A digit is accepted once its {anode, segment} sample has been
//   stable for STABLE_CYCLES consecutive samples; when every digit position
//   has been accepted the full word is published with a one-cycle o_valid.
//   Optional feature macro: SEG7DEC_ERRCNT_EN adds o_err_cnt.
//   Parameters:
//     STABLE_CYCLES  identical samples needed to accept a digit (1..255)
//     NUM_DIGITS     number of multiplexed digit positions
//   Ports:
//     i_clk                  clock, rising edge
//     i_rst                  synchronous active-high reset
//     i_seg     [0:6]        active-low segments, bit 0 = a ... bit 6 = g
//     i_an      [ND-1:0]     active-low digit enables (one-hot-low or all-high)
//     o_word    [4*ND-1:0]   recovered word, digit k in bits [4k+3:4k]
//     o_valid                one-cycle pulse per recovered frame
//     o_err                  one-cycle pulse on illegal pattern / anode vector
//     o_err_cnt [7:0]        saturating o_err count (SEG7DEC_ERRCNT_EN only)
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | display blanked or after an illegal anode vector; no digit
//   ST_COUNT | one digit enabled, counting consecutive identical samples
//   ST_HOLD  | current sample already accepted; wait for it to change
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [0:6]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_an,
  output logic [4*NUM_DIGITS-1:0] o_word,
  output logic                    o_valid,
  output logic                    o_err
`ifdef SEG7DEC_ERRCNT_EN
  ,
  output logic [7:0]              o_err_cnt
`endif
);
  import seg7_pkg::*;

  localparam int LOW_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  scan_state_t             state;
  logic [NUM_DIGITS-1:0]   smp_an;
  logic [NUM_DIGITS-1:0]   prev_an;
  logic [0:6]              smp_seg;
  logic [0:6]              prev_seg;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_new;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   seen_cap;
  logic [4*NUM_DIGITS-1:0] slots;
  logic [4*NUM_DIGITS-1:0] slots_cap;
  logic [LOW_W-1:0]        low_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              pat_nibble;
  logic                    pat_legal;
  logic                    an_blank;
  logic                    an_onehot;
  logic                    an_multi;
  logic                    same;
  logic                    hold_keep;
  logic                    capture;
  logic                    frame_done;
  logic                    err_evt;

  seg7_pattern_decode u_decode (
    .pattern (smp_seg),
    .nibble  (pat_nibble),
    .legal   (pat_legal)
  );

  // Number of enabled (low) anodes and the position of the enabled one.
  always_comb begin
    low_cnt   = '0;
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!smp_an[i]) begin
        low_cnt   = low_cnt + LOW_W'(1);
        digit_idx = IDX_W'(i);
      end
    end
  end

  assign an_blank  = (low_cnt == '0);
  assign an_onehot = (low_cnt == LOW_W'(1));
  assign an_multi  = !an_blank && !an_onehot;
  assign same      = (smp_an == prev_an) && (smp_seg == prev_seg);
  assign hold_keep = (state == ST_HOLD) && same;

  // Any entry into counting (from IDLE, HOLD, or a changed sample) starts at 1,
  // so STABLE_CYCLES == 1 accepts on the very first sample.
  assign cnt_new = ((state == ST_COUNT) && same)
                 ? ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1))
                 : CNT_W'(1);

  assign capture = an_onehot && !hold_keep && (cnt_new == CNT_TC);

  // A held illegal anode vector reports once; a new illegal vector reports again.
  assign err_evt = (an_multi && (smp_an != prev_an)) || (capture && !pat_legal);

  always_comb begin
    slots_cap                   = slots;
    slots_cap[4*digit_idx +: 4] = pat_nibble;
  end

  assign seen_cap   = seen | ~smp_an;
  assign frame_done = &seen_cap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      smp_an   <= '1;
      smp_seg  <= '1;
      prev_an  <= '1;
      prev_seg <= '1;
      cnt      <= '0;
      seen     <= '0;
      slots    <= '0;
      o_word   <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      smp_an   <= i_an;
      smp_seg  <= i_seg;
      prev_an  <= smp_an;
      prev_seg <= smp_seg;
      o_valid  <= 1'b0;
      o_err    <= err_evt;

      // Illegal or blank anodes take priority, so no capture can coincide.
      if (an_multi || an_blank) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (!hold_keep) begin
        cnt <= cnt_new;
        if (capture) begin
          state <= ST_HOLD;
          if (pat_legal) begin
            slots <= slots_cap;
            if (frame_done) begin
              o_word  <= slots_cap;
              o_valid <= 1'b1;
              seen    <= '0;
            end else begin
              seen <= seen_cap;
            end
          end
        end else begin
          state <= ST_COUNT;
        end
      end
    end
  end

`ifdef SEG7DEC_ERRCNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if (err_evt && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Self-checking bench for seg7_scan_decoder: per-cycle comparison against a
//   run-length reference model, a table of decode frames, directed corner
//   sequences, and randomized bus traffic.
module tb_seg7_scan_decoder;
  localparam int STABLE = 4;
  localparam int ND     = 4;

  localparam logic [0:6] HEX_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] word;
  logic        valid;
  logic        err;
`ifdef SEG7DEC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .NUM_DIGITS(ND)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_seg   (seg),
    .i_an    (an),
    .o_word  (word),
    .o_valid (valid),
    .o_err   (err)
`ifdef SEG7DEC_ERRCNT_EN
    ,
    .o_err_cnt (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int obs_valid;
  int obs_err;
  logic [15:0] last_word;

  // Reference model: tracks the length of the current run of identical
  // single-digit samples and whether that run has already been accepted.
  logic [3:0]  m_smp_an, m_prev_an;
  logic [0:6]  m_smp_seg, m_prev_seg;
  int          rl;
  bit          acc;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [15:0] m_word;
  bit          e_valid, e_err;
  int          m_errcnt;

  function automatic int lookup(input logic [0:6] s);
    for (int v = 0; v < 16; v++) if (HEX_TBL[v] == s) return v;
    return -1;
  endfunction

  task automatic model_decide();
    int nlow;
    int k;
    int v;
    nlow = 0;
    k    = 0;
    for (int i = 0; i < ND; i++) if (!m_smp_an[i]) begin nlow++; k = i; end
    if (nlow > 1) begin
      if (m_smp_an != m_prev_an) e_err = 1'b1;
      rl = 0; acc = 1'b0;
    end else if (nlow == 0) begin
      rl = 0; acc = 1'b0;
    end else begin
      if (rl > 0 && m_smp_an == m_prev_an && m_smp_seg == m_prev_seg) rl++;
      else begin rl = 1; acc = 1'b0; end
      if (!acc && rl == STABLE) begin
        acc = 1'b1;
        v = lookup(m_smp_seg);
        if (v < 0) e_err = 1'b1;
        else begin
          m_slot[k] = v[3:0];
          m_seen[k] = 1'b1;
          if (&m_seen) begin
            for (int d = 0; d < ND; d++) m_word[4*d +: 4] = m_slot[d];
            e_valid = 1'b1;
            m_seen  = '0;
          end
        end
      end
    end
    if (e_err && m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model_edge();
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      m_smp_an = 4'hF; m_prev_an = 4'hF;
      m_smp_seg = 7'h7F; m_prev_seg = 7'h7F;
      rl = 0; acc = 1'b0; m_seen = '0; m_word = '0; m_errcnt = 0;
      for (int d = 0; d < ND; d++) m_slot[d] = '0;
    end else begin
      model_decide();
      m_prev_an  = m_smp_an;
      m_prev_seg = m_smp_seg;
      m_smp_an   = an;
      m_smp_seg  = seg;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [0:6] s, input logic r);
    @(negedge clk);
    an = a; seg = s; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("cyc_valid", 32'(valid), 32'(e_valid));
    check("cyc_err",   32'(err),   32'(e_err));
    check("cyc_word",  32'(word),  32'(m_word));
`ifdef SEG7DEC_ERRCNT_EN
    check("cyc_err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
    if (valid) begin obs_valid++; last_word = word; end
    if (err) obs_err++;
  endtask

  task automatic digit(input int d, input logic [0:6] s, input int n);
    logic [3:0] a;
    a = 4'b0001 << d;
    a = ~a;
    repeat (n) step(a, s, 1'b0);
  endtask

  task automatic blank(input int n);
    repeat (n) step(4'hF, 7'h7F, 1'b0);
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_err = 0; last_word = '0;
  endtask

  typedef struct {
    logic [0:6] seg;
    bit         legal;
    logic [3:0] nib;
  } vec_t;

  vec_t        tbl [20];
  logic [15:0] tbl_word;
  logic [3:0]  r_an;
  logic [0:6]  r_seg;
  int          r_hold;

  initial begin
    for (int v = 0; v < 16; v++) tbl[v] = '{HEX_TBL[v], 1'b1, v[3:0]};
    tbl[16] = '{7'b1111111, 1'b0, 4'h0};
    tbl[17] = '{7'b1111110, 1'b0, 4'h0};
    tbl[18] = '{7'b0000011, 1'b0, 4'h0};
    tbl[19] = '{7'b1010101, 1'b0, 4'h0};

    an = 4'hF; seg = 7'h7F; rst = 1'b1;
    clear_obs();
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    check("reset_word",  32'(word),  32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err",   32'(err),   32'h0);

    // Decode table: every digit shows the same glyph.
    tbl_word = '0;
    for (int t = 0; t < 20; t++) begin
      clear_obs();
      for (int d = 0; d < ND; d++) digit(d, tbl[t].seg, STABLE);
      blank(2);
      if (tbl[t].legal) begin
        tbl_word = {4{tbl[t].nib}};
        check($sformatf("tbl%0d_valid", t), 32'(obs_valid), 32'd1);
        check($sformatf("tbl%0d_word", t),  32'(last_word), 32'(tbl_word));
      end else begin
        check($sformatf("tbl%0d_err", t),   32'(obs_err),   32'd4);
        check($sformatf("tbl%0d_novld", t), 32'(obs_valid), 32'd0);
        check($sformatf("tbl%0d_hold", t),  32'(word),      32'(tbl_word));
      end
    end

    // Basic frame 3,9,A,F.
    step(4'hF, 7'h7F, 1'b1);
    clear_obs();
    digit(0, HEX_TBL[3], 4);
    digit(1, HEX_TBL[9], 4);
    digit(2, HEX_TBL[10], 4);
    digit(3, HEX_TBL[15], 4);
    blank(2);
    check("frame_valid_cnt", 32'(obs_valid), 32'd1);
    check("frame_word",      32'(last_word), 32'hFA93);

    // Digit 0 one sample short of stable: never recorded.
    clear_obs();
    digit(0, HEX_TBL[5], 3);
    digit(1, HEX_TBL[1], 4);
    digit(2, HEX_TBL[2], 4);
    digit(3, HEX_TBL[3], 4);
    blank(2);
    check("short_novalid", 32'(obs_valid), 32'd0);
    digit(0, HEX_TBL[7], 4);
    blank(2);
    check("short_then_valid", 32'(obs_valid), 32'd1);
    check("short_then_word",  32'(last_word), 32'h3217);

    // Illegal glyph held for 6 cycles.
    clear_obs();
    digit(2, 7'b1111111, 6);
    blank(2);
    check("badseg_err_cnt", 32'(obs_err),   32'd1);
    check("badseg_novalid", 32'(obs_valid), 32'd0);
    check("badseg_word",    32'(word),      32'h3217);

    // Illegal anode vector in mid-frame keeps captured slots.
    clear_obs();
    digit(0, HEX_TBL[12], 4);
    digit(1, HEX_TBL[13], 4);
    step(4'b1100, HEX_TBL[0], 1'b0);
    digit(2, HEX_TBL[14], 4);
    digit(3, HEX_TBL[11], 4);
    blank(2);
    check("badan_err_cnt", 32'(obs_err),   32'd1);
    check("badan_valid",   32'(obs_valid), 32'd1);
    check("badan_word",    32'(last_word), 32'hBEDC);

    // Reset after partial frame (and mid-count) discards it.
    clear_obs();
    digit(0, HEX_TBL[8], 4);
    digit(1, HEX_TBL[6], 4);
    digit(2, HEX_TBL[5], 2);
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    check("midrst_word", 32'(word), 32'h0);
    digit(0, HEX_TBL[1], 4);
    digit(1, HEX_TBL[2], 4);
    digit(2, HEX_TBL[3], 4);
    digit(3, HEX_TBL[4], 4);
    blank(2);
    check("midrst_valid_cnt", 32'(obs_valid), 32'd1);
    check("midrst_word2",     32'(last_word), 32'h4321);

    // 300 illegal glyph captures.
    clear_obs();
    for (int i = 0; i < 300; i++) digit(0, (i % 2 == 0) ? 7'h7F : 7'h7E, STABLE);
    blank(2);
    check("many_err_pulses", 32'(obs_err),   32'd300);
    check("many_novalid",    32'(obs_valid), 32'd0);
`ifdef SEG7DEC_ERRCNT_EN
    check("many_err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    // Random bus traffic, checked every cycle against the model.
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 70) begin
        r_an = 4'b0001 << $urandom_range(0, 3);
        r_an = ~r_an;
      end else if (sel < 85) r_an = 4'hF;
      else r_an = 4'($urandom);
      if ($urandom_range(0, 9) < 8) r_seg = HEX_TBL[$urandom_range(0, 15)];
      else r_seg = 7'($urandom);
      r_hold = $urandom_range(1, 7);
      repeat (r_hold) step(r_an, r_seg, 1'b0);
      if ($urandom_range(0, 59) == 0) step(r_an, r_seg, 1'b1);
    end
    blank(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
